npc_ctrl: RTL and testbench
===========================

// Module: npc_ctrl
// PURPOSE
//  Next-PC controller that sequences the ifu. Arbitrates redirect requests from decode/execute
//  (branch, jump, jr, exception) into a single npc_sel/npc pair plus a PC write enable.
//  Buffers one redirect across pipeline stalls and optionally squashes the post-redirect fetch.
//  Sits between the hazard/decode logic and the ifu npc_sel/npc/pc_en inputs.
// PARAMETERS
//  EXC_VECTOR  32'h0000_4180  absolute address driven on npc for an exception redirect
//  DELAY_SLOT  1              1: MIPS delay slot executes; 0: flush one fetch after each redirect
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   asynchronous, active-low (reset==0 clears all state immediately)
//  stall      in   1   1 = hold PC this cycle (hazard unit)
//  br_take    in   1   taken conditional branch -> IFU_SEL_RELATIVE
//  j_req      in   1   j/jal -> IFU_SEL_IRRELATIVE
//  jr_req     in   1   jr/jalr -> IFU_SEL_REGISTER with npc=jr_addr
//  jr_addr    in   32  register jump target
//  exc_req    in   1   exception -> IFU_SEL_REGISTER with npc=EXC_VECTOR
//  npc_sel    out  2   IFU_SEL_* code to ifu (combinational from state/pending/inputs)
//  npc        out  32  register-mode target to ifu; 0 when npc_sel != IFU_SEL_REGISTER
//  pc_en      out  1   ifu PC write enable
//  flush      out  1   registered; squash instruction in fetch (DELAY_SLOT==0 only)
// BEHAVIOUR
//  - Reset: state=BOOT, pend_vld=0, pend_sel=NORM, pend_npc=0; outputs npc_sel=NORM, npc=0,
//    pc_en=0, flush=0. Reset mid-HOLD/FLUSH discards pending redirect.
//  - Priority (fixed): exc_req > jr_req > j_req > br_take > NORM. Pending outranks new
//    requests of equal or lower priority; a strictly higher new request replaces it.
//  - BOOT: one cycle, pc_en=0 (first fetch at ifu reset PC completes) -> RUN.
//  - RUN, stall=0: issue winner combinationally, pc_en=1. Winner != NORM and DELAY_SLOT==0
//    -> FLUSH; else stay RUN.
//  - RUN, stall=1: pc_en=0, npc_sel=NORM. Any request -> latch winner into pend, -> HOLD.
//  - HOLD, stall=1: pc_en=0; merge new requests per priority rule.
//  - HOLD, stall=0: issue merged winner (pend vs new), pc_en=1, clear pend_vld;
//    -> FLUSH if DELAY_SLOT==0 else RUN.
//  - FLUSH: flush=1 for exactly this cycle (registered, set on redirect edge); npc_sel=NORM,
//    pc_en=!stall; br/j/jr from the squashed slot ignored; exc_req honoured as in RUN.
//  - exc_req bypasses stall in every state except BOOT: pc_en=1, npc=EXC_VECTOR same cycle,
//    pend cleared.
//  - Simultaneous requests in one cycle: only winner acted on, others dropped (decode
//    guarantees at most one of br/j/jr per instruction; exc may coincide).
//  - npc output width 32, no arithmetic here; relative/absolute targets computed inside ifu.
// STRUCTURE
//  - defines.v: reuse IFU_SEL_NORM/RELATIVE/IRRELATIVE/REGISTER; add NPC_ST_BOOT/RUN/HOLD/FLUSH
//    (2-bit) and NPC_PRIO_* rank constants.
//  - Sub-module npc_arb: combinational priority pick over {pend, exc, jr, j, br} -> sel, npc, rank.
//  - npc_ctrl: state register, pending register, flush register, output muxing.
// TESTING (bench ties npc_ctrl to ifu, readmemh program at 0x3000)
//  1 Reset low 10ns then high, no requests -> BOOT 1 cycle pc_en=0, then PC 0x3000,0x3004,0x3008.
//  2 br_take=1 one cycle, stall=0 -> npc_sel=RELATIVE, pc_en=1 same cycle, PC=branch target
//    next edge; DELAY_SLOT=0 build: flush=1 for exactly 1 cycle after.
//  3 stall=1 3 cycles, j_req pulse in cycle 1 -> pc_en=0, PC frozen; stall drop -> npc_sel=
//    IRRELATIVE, PC=(index<<2) next edge, then NORM.
//  4 stall=1, br_take then jr_req(jr_addr=0x3040) in HOLD -> on release npc_sel=REGISTER,
//    npc=0x3040, PC=0x3040; branch dropped.
//  5 stall=1 with pend jr, exc_req pulse -> pc_en=1 despite stall, npc=0x4180, pend cleared,
//    no later jr issue.
//  6 Pull reset low during HOLD -> all outputs reset values immediately; after release
//    pending redirect never issued, sequence restarts from BOOT.

Source files
------------

// File: rtl/npc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl_pkg
// Description : Shared types and constants for the next-PC controller:
//               IFU select codes, controller state encoding, redirect ranks.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_ctrl_pkg;

    // Select codes understood by the ifu next-PC mux
    typedef enum logic [1:0] {
        IFU_SEL_NORM       = 2'd0,
        IFU_SEL_RELATIVE   = 2'd1,
        IFU_SEL_IRRELATIVE = 2'd2,
        IFU_SEL_REGISTER   = 2'd3
    } ifu_sel_e;

    // Controller states
    typedef enum logic [1:0] {
        NPC_ST_BOOT  = 2'd0,
        NPC_ST_RUN   = 2'd1,
        NPC_ST_HOLD  = 2'd2,
        NPC_ST_FLUSH = 2'd3
    } npc_state_e;

    // Redirect ranks, higher value wins
    localparam logic [2:0] NPC_PRIO_NORM = 3'd0;
    localparam logic [2:0] NPC_PRIO_BR   = 3'd1;
    localparam logic [2:0] NPC_PRIO_J    = 3'd2;
    localparam logic [2:0] NPC_PRIO_JR   = 3'd3;
    localparam logic [2:0] NPC_PRIO_EXC  = 3'd4;

    // Rank of a buffered redirect. Exceptions are never buffered, so a
    // REGISTER select held in the pending slot is always a jr.
    function automatic logic [2:0] sel_rank(input ifu_sel_e sel);
        case (sel)
            IFU_SEL_RELATIVE:   sel_rank = NPC_PRIO_BR;
            IFU_SEL_IRRELATIVE: sel_rank = NPC_PRIO_J;
            IFU_SEL_REGISTER:   sel_rank = NPC_PRIO_JR;
            default:            sel_rank = NPC_PRIO_NORM;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl_if
// Description : Redirect request / next-PC bundle between hazard+decode
//               logic (master) and the next-PC controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_ctrl_if;
    import npc_ctrl_pkg::*;

    logic        stall;
    logic        br_take;
    logic        j_req;
    logic        jr_req;
    logic [31:0] jr_addr;
    logic        exc_req;
    ifu_sel_e    npc_sel;
    logic [31:0] npc;
    logic        pc_en;
    logic        flush;

    modport master (
        output stall, br_take, j_req, jr_req, jr_addr, exc_req,
        input  npc_sel, npc, pc_en, flush
    );

    modport slave (
        input  stall, br_take, j_req, jr_req, jr_addr, exc_req,
        output npc_sel, npc, pc_en, flush
    );

endinterface
`default_nettype wire

// File: rtl/npc_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl_arb
// Description : Combinational priority pick between the buffered redirect
//               and this cycle's requests. A new request replaces the
//               pending one only when strictly higher ranked.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_ctrl_arb
    import npc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  wire logic        i_pend_vld,
    input  wire ifu_sel_e    i_pend_sel,
    input  wire logic [31:0] i_pend_npc,
    input  wire logic        i_exc_req,
    input  wire logic        i_jr_req,
    input  wire logic [31:0] i_jr_addr,
    input  wire logic        i_j_req,
    input  wire logic        i_br_take,
    output ifu_sel_e         o_sel,
    output logic [31:0]      o_npc,
    output logic [2:0]       o_rank
);

    ifu_sel_e    w_new_sel;
    logic [31:0] w_new_npc;
    logic [2:0]  w_new_rank;
    logic [2:0]  w_pend_rank;

    // Fixed-priority pick among this cycle's requests
    always_comb begin
        w_new_sel  = IFU_SEL_NORM;
        w_new_npc  = 32'd0;
        w_new_rank = NPC_PRIO_NORM;
        if (i_exc_req) begin
            w_new_sel  = IFU_SEL_REGISTER;
            w_new_npc  = EXC_VECTOR;
            w_new_rank = NPC_PRIO_EXC;
        end else if (i_jr_req) begin
            w_new_sel  = IFU_SEL_REGISTER;
            w_new_npc  = i_jr_addr;
            w_new_rank = NPC_PRIO_JR;
        end else if (i_j_req) begin
            w_new_sel  = IFU_SEL_IRRELATIVE;
            w_new_rank = NPC_PRIO_J;
        end else if (i_br_take) begin
            w_new_sel  = IFU_SEL_RELATIVE;
            w_new_rank = NPC_PRIO_BR;
        end
    end

    assign w_pend_rank = i_pend_vld ? sel_rank(i_pend_sel) : NPC_PRIO_NORM;

    // Pending wins ties; new request wins only when strictly higher
    always_comb begin
        o_sel  = IFU_SEL_NORM;
        o_npc  = 32'd0;
        o_rank = NPC_PRIO_NORM;
        if (w_new_rank > w_pend_rank) begin
            o_sel  = w_new_sel;
            o_npc  = w_new_npc;
            o_rank = w_new_rank;
        end else if (i_pend_vld) begin
            o_sel  = i_pend_sel;
            o_npc  = (i_pend_sel == IFU_SEL_REGISTER) ? i_pend_npc : 32'd0;
            o_rank = w_pend_rank;
        end
    end

endmodule
`default_nettype wire

// File: rtl/npc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl
// Description : Next-PC controller. Arbitrates branch/jump/jr/exception
//               redirects into npc_sel/npc/pc_en for the ifu, buffers one
//               redirect across stalls, optionally squashes the fetch that
//               follows a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          DELAY_SLOT = 1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    npc_ctrl_if.slave  bus
);

    localparam logic c_squash = (DELAY_SLOT == 0);

    npc_state_e  r_state;
    logic        r_pend_vld;
    ifu_sel_e    r_pend_sel;
    logic [31:0] r_pend_npc;
    logic        r_flush;

    ifu_sel_e    w_arb_sel;
    logic [31:0] w_arb_npc;
    logic [2:0]  w_arb_rank;
    ifu_sel_e    w_sel;
    logic [31:0] w_npc;
    logic        w_pc_en;
    logic        w_issue;
    logic        w_to_flush;

    npc_ctrl_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .i_pend_vld (r_pend_vld),
        .i_pend_sel (r_pend_sel),
        .i_pend_npc (r_pend_npc),
        .i_exc_req  (bus.exc_req),
        .i_jr_req   (bus.jr_req),
        .i_jr_addr  (bus.jr_addr),
        .i_j_req    (bus.j_req),
        .i_br_take  (bus.br_take),
        .o_sel      (w_arb_sel),
        .o_npc      (w_arb_npc),
        .o_rank     (w_arb_rank)
    );

    // Output decode: issue the arbitrated redirect when the PC may advance;
    // an exception overrides stall everywhere except BOOT.
    always_comb begin
        w_sel   = IFU_SEL_NORM;
        w_npc   = 32'd0;
        w_pc_en = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            NPC_ST_RUN, NPC_ST_HOLD: begin
                w_issue = bus.exc_req | ~bus.stall;
            end
            NPC_ST_FLUSH: begin
                // Squashed slot: only an exception may redirect
                w_issue = bus.exc_req;
                w_pc_en = ~bus.stall;
            end
            default: ;
        endcase
        if (w_issue) begin
            w_sel   = w_arb_sel;
            w_npc   = w_arb_npc;
            w_pc_en = 1'b1;
        end
    end

    assign w_to_flush = w_issue && (w_arb_sel != IFU_SEL_NORM) && c_squash;

    assign bus.npc_sel = w_sel;
    assign bus.npc     = w_npc;
    assign bus.pc_en   = w_pc_en;
    assign bus.flush   = r_flush;

    // State, pending redirect and flush registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= NPC_ST_BOOT;
            r_pend_vld <= 1'b0;
            r_pend_sel <= IFU_SEL_NORM;
            r_pend_npc <= 32'd0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= w_to_flush;
            case (r_state)
                NPC_ST_BOOT: begin
                    r_state <= NPC_ST_RUN;
                end
                NPC_ST_RUN, NPC_ST_HOLD: begin
                    if (w_issue) begin
                        r_pend_vld <= 1'b0;
                        r_pend_sel <= IFU_SEL_NORM;
                        r_pend_npc <= 32'd0;
                        r_state    <= w_to_flush ? NPC_ST_FLUSH : NPC_ST_RUN;
                    end else if (w_arb_rank != NPC_PRIO_NORM) begin
                        r_pend_vld <= 1'b1;
                        r_pend_sel <= w_arb_sel;
                        r_pend_npc <= w_arb_npc;
                        r_state    <= NPC_ST_HOLD;
                    end
                end
                NPC_ST_FLUSH: begin
                    r_state <= w_to_flush ? NPC_ST_FLUSH : NPC_ST_RUN;
                end
                default: begin
                    r_state <= NPC_ST_BOOT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_ctrl
// Description : Self-checking bench for npc_ctrl. One instance without delay
//               slot (flush active), one with delay slot, both on the same
//               request stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_ctrl;

    localparam logic [31:0] c_vec = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        stall, br_take, j_req, jr_req, exc_req;
    logic [31:0] jr_addr;

    int n_chk  = 0;
    int n_fail = 0;

    npc_ctrl_if bus0 ();
    npc_ctrl_if bus1 ();

    assign bus0.stall   = stall;   assign bus1.stall   = stall;
    assign bus0.br_take = br_take; assign bus1.br_take = br_take;
    assign bus0.j_req   = j_req;   assign bus1.j_req   = j_req;
    assign bus0.jr_req  = jr_req;  assign bus1.jr_req  = jr_req;
    assign bus0.jr_addr = jr_addr; assign bus1.jr_addr = jr_addr;
    assign bus0.exc_req = exc_req; assign bus1.exc_req = exc_req;

    npc_ctrl #(.EXC_VECTOR(c_vec), .DELAY_SLOT(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    npc_ctrl #(.EXC_VECTOR(c_vec), .DELAY_SLOT(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    logic [1:0]  act_sel [2];
    logic [31:0] act_npc [2];
    logic        act_pen [2];
    logic        act_fl  [2];
    assign act_sel[0] = bus0.npc_sel; assign act_sel[1] = bus1.npc_sel;
    assign act_npc[0] = bus0.npc;     assign act_npc[1] = bus1.npc;
    assign act_pen[0] = bus0.pc_en;   assign act_pen[1] = bus1.pc_en;
    assign act_fl[0]  = bus0.flush;   assign act_fl[1]  = bus1.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = first cycle after reset, 1 = normal, 2 = squash cycle.
    // A pending redirect is just a remembered (rank, target) pair.
    int          m_phase [2];
    int          m_prank [2];
    logic [31:0] m_paddr [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_prank[k] = 0;
            m_paddr[k] = 32'd0;
        end
    endtask

    // Compare both instances against the model for the current inputs,
    // then advance the model past the coming clock edge.
    task automatic model_step();
        int          nr, er, es, nphase;
        logic [31:0] na, ea;
        bit          ep, ef, ds;
        nr = exc_req ? 4 : jr_req ? 3 : j_req ? 2 : br_take ? 1 : 0;
        na = exc_req ? c_vec : jr_addr;
        for (int k = 0; k < 2; k++) begin
            ds = (k == 1);
            er = 0; ea = 32'd0; ep = 1'b0;
            ef = (m_phase[k] == 2);
            nphase = 1;
            if (m_phase[k] == 2) begin
                ep = !stall;
                if (exc_req) begin
                    er = 4; ea = c_vec; ep = 1'b1;
                    nphase = ds ? 1 : 2;
                end
            end else if (m_phase[k] == 1) begin
                if (nr > m_prank[k]) begin er = nr; ea = na; end
                else begin er = m_prank[k]; ea = m_paddr[k]; end
                if (exc_req || !stall) begin
                    ep = 1'b1;
                    m_prank[k] = 0;
                    nphase = (er != 0 && !ds) ? 2 : 1;
                end else begin
                    if (er != 0) begin m_prank[k] = er; m_paddr[k] = ea; end
                    er = 0;
                end
            end
            es = (er >= 3) ? 3 : er;
            chk($sformatf("npc_sel[ds=%0d]", ds), {30'd0, act_sel[k]}, es);
            chk($sformatf("npc[ds=%0d]", ds), act_npc[k], (es == 3) ? ea : 32'd0);
            chk($sformatf("pc_en[ds=%0d]", ds), {31'd0, act_pen[k]}, {31'd0, ep});
            chk($sformatf("flush[ds=%0d]", ds), {31'd0, act_fl[k]}, {31'd0, ef});
            m_phase[k] = nphase;
        end
    endtask

    task automatic drive(input bit s, input bit b, input bit j, input bit r,
                         input logic [31:0] a, input bit e);
        stall = s; br_take = b; j_req = j; jr_req = r; jr_addr = a; exc_req = e;
    endtask

    // Inputs are set right after a rising edge; outputs checked at the falling edge
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_npc_sel"}, {30'd0, act_sel[k]}, 32'd0);
            chk({tag, "_npc"}, act_npc[k], 32'd0);
            chk({tag, "_pc_en"}, {31'd0, act_pen[k]}, 32'd0);
            chk({tag, "_flush"}, {31'd0, act_fl[k]}, 32'd0);
        end
    endtask

    // ---------------- directed table (no-delay-slot instance) ----------------
    typedef struct {
        bit          s, b, j, r;
        logic [31:0] a;
        bit          e;
        int          sel;
        logic [31:0] npc;
        bit          pen, fl;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(bit s, bit b, bit j, bit r, logic [31:0] a, bit e,
                                int sel, logic [31:0] npc, bit pen, bit fl);
        vec_t v;
        v.s = s; v.b = b; v.j = j; v.r = r; v.a = a; v.e = e;
        v.sel = sel; v.npc = npc; v.pen = pen; v.fl = fl;
        return v;
    endfunction

    initial begin
        //            stall br j jr addr          exc  sel npc      pen fl
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    0, 0); // BOOT
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 0);
        tbl[2]  = mk(0, 1, 0, 0, 32'h0,      0,   1, 32'h0,    1, 0); // branch
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 1); // squash
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 0);
        tbl[5]  = mk(1, 0, 1, 0, 32'h0,      0,   0, 32'h0,    0, 0); // j in stall
        tbl[6]  = mk(1, 0, 0, 0, 32'h0,      0,   0, 32'h0,    0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0,      0,   0, 32'h0,    0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,      0,   2, 32'h0,    1, 0); // release j
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 1);
        tbl[10] = mk(1, 1, 0, 0, 32'h0,      0,   0, 32'h0,    0, 0); // br held
        tbl[11] = mk(1, 0, 0, 1, 32'h3040,   0,   0, 32'h0,    0, 0); // jr replaces
        tbl[12] = mk(0, 0, 0, 0, 32'h0,      0,   3, 32'h3040, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 32'h1234,   0,   0, 32'h0,    1, 1); // squashed jr
        tbl[14] = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 0);
        tbl[15] = mk(1, 0, 0, 1, 32'h3040,   0,   0, 32'h0,    0, 0); // pend jr
        tbl[16] = mk(1, 0, 0, 0, 32'h0,      1,   3, 32'h4180, 1, 0); // exc bypass
        tbl[17] = mk(1, 0, 0, 0, 32'h0,      0,   0, 32'h0,    0, 1);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 0); // jr gone
        tbl[19] = mk(1, 0, 1, 0, 32'h0,      0,   0, 32'h0,    0, 0); // pend j
        tbl[20] = mk(1, 1, 0, 0, 32'h0,      0,   0, 32'h0,    0, 0); // lower br
        tbl[21] = mk(0, 0, 0, 0, 32'h0,      0,   2, 32'h0,    1, 0);
        tbl[22] = mk(0, 0, 0, 0, 32'h0,      1,   3, 32'h4180, 1, 1); // exc in squash
        tbl[23] = mk(0, 0, 0, 0, 32'h0,      0,   0, 32'h0,    1, 1);
        tbl[24] = mk(0, 0, 1, 0, 32'h0,      0,   2, 32'h0,    1, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0);
        model_reset();
        #8;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed table
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].r, tbl[i].a, tbl[i].e);
            @(negedge clk);
            chk($sformatf("tbl%0d_sel", i), {30'd0, bus0.npc_sel}, tbl[i].sel);
            chk($sformatf("tbl%0d_npc", i), bus0.npc, tbl[i].npc);
            chk($sformatf("tbl%0d_pc_en", i), {31'd0, bus0.pc_en}, {31'd0, tbl[i].pen});
            chk($sformatf("tbl%0d_flush", i), {31'd0, bus0.flush}, {31'd0, tbl[i].fl});
            model_step();
            @(posedge clk);
            #1;
        end

        // Reset asserted while a jr is pending in HOLD
        drive(1, 0, 0, 1, 32'h3040, 0);
        cycle();
        drive(1, 0, 0, 0, 32'h0, 0);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("hold_reset");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 0);
        cycle();           // BOOT again, pc_en low
        cycle();           // plain fetch, no stale jr
        cycle();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 4,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 10,
                  $urandom,
                  $urandom_range(0, 99) < 5);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
